// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: one round per clock, start/busy/done handshake.
// It consumes a pre-expanded 1408-bit key schedule. The output register updates only on completion.

// Forward S-box for one byte lane; the table is packed with entry 0 in the top byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Entry a sits at bit 2047-8*a, which is {~a, 3'b111}.
    assign y = TBL[{~a, 3'b111} -: 8];
endmodule

module aes_cipher_iter #(
    parameter int NR = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [127:0]   in,
    input  logic [1407:0]  w,
    output logic           busy,
    output logic           done,
    output logic [127:0]   out
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

    localparam logic [3:0] LAST = 4'(NR);
    localparam logic [3:0] PEN  = 4'(NR - 1);

    state_t        cur, nxt;
    logic [3:0]    rnd, rnd_n;
    logic [127:0]  state_reg, state_n, out_n;
    logic          busy_n, done_n;
    logic [127:0]  sb, sr, mc, rk;

    // Byte 0 is bits [127:120]. The state is column-major, so byte 4c+r is row r, column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // SubBytes is sixteen byte lanes. ROUND and FINAL both read the S-box output of state_reg.
    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_lane
            aes_sbox u_sbox (.a(state_reg[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
        end
    endgenerate

    assign sr = shift_rows(sb);
    assign mc = mix_columns(sr);

    // Select round key rnd from the schedule. Round 0 is in the top 128 bits.
    always_comb begin
        rk = '0;
        for (int r = 0; r <= NR; r++)
            if (rnd == 4'(r)) rk = w[128*(NR-r) +: 128];
    end

    // Next-state logic and datapath. Any illegal state or counter value goes back to IDLE.
    always_comb begin
        nxt     = cur;
        rnd_n   = rnd;
        state_n = state_reg;
        out_n   = out;
        busy_n  = busy;
        done_n  = 1'b0;
        case (cur)
            IDLE: begin
                if (start) begin
                    state_n = in ^ w[128*NR +: 128];
                    rnd_n   = 4'd1;
                    busy_n  = 1'b1;
                    nxt     = ROUND;
                end
            end
            ROUND: begin
                if (rnd >= 4'd1 && rnd <= PEN) begin
                    state_n = mc ^ rk;
                    rnd_n   = rnd + 4'd1;
                    if (rnd == PEN) nxt = FINAL;
                end else begin
                    nxt    = IDLE;
                    rnd_n  = 4'd0;
                    busy_n = 1'b0;
                end
            end
            FINAL: begin
                if (rnd == LAST) begin
                    out_n  = sr ^ w[127:0];
                    done_n = 1'b1;
                end
                nxt    = IDLE;
                rnd_n  = 4'd0;
                busy_n = 1'b0;
            end
            default: begin
                nxt    = IDLE;
                rnd_n  = 4'd0;
                busy_n = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any operation in progress and clears out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= IDLE;
            rnd       <= 4'd0;
            state_reg <= '0;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur       <= nxt;
            rnd       <= rnd_n;
            state_reg <= state_n;
            out       <= out_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end
endmodule
